ntru_axis_poly_streamer: RTL and testbench

- AXI4-Stream master that streams one polynomial from a coefficient RAM into the ntru_polymul slave input (S_AXIS_MM2S).
- Issues sequential RAM reads for addresses 0..poly_n-1 and absorbs the 1-cycle RAM read latency with a 2-entry skid FIFO, so backpressure never drops or duplicates a word.
- Asserts tlast on the final coefficient and pulses done after the last handshake.
- Sits between the DMA/BRAM staging buffer and ntru_polymul.

---
 rtl/ntru_stream_pkg.sv | 16 +
 rtl/ntru_skid_fifo.sv | 62 ++++++
 rtl/ntru_axis_poly_streamer.sv | 127 ++++++++++++
 tb/tb_ntru_axis_poly_streamer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntru_stream_pkg.sv
// Shared types and constants for the NTRU polynomial streamer.
// FSM encoding, default widths and skid FIFO sizing.
package ntru_stream_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } state_e;

endpackage

// File: rtl/ntru_skid_fifo.sv
// Two-entry registered skid FIFO; head is always slot0.
// Synchronous active-low reset.
module ntru_skid_fifo
  import ntru_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] slot0_q;
  logic [DATA_W-1:0] slot1_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = slot0_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (empty) slot0_q <= din;
          else       slot1_q <= din;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        2'b01: begin
          slot0_q <= slot1_q;
          cnt_q   <= cnt_q - CNT_W'(1);
        end
        2'b11: begin
          // count stays put; refill behind the departing head
          if (full) begin
            slot0_q <= slot1_q;
            slot1_q <= din;
          end else begin
            slot0_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ntru_axis_poly_streamer.sv
// Streams poly_n RAM words to an AXI4-Stream slave via a skid FIFO.
// NTRU_STREAM_CYCLECOUNT_EN enables the busy-cycle counter.
module ntru_axis_poly_streamer
  import ntru_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] poly_n,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  output logic              M_AXIS_tlast,
  output logic [31:0]       cycle_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic [ADDR_W-1:0] beat_cnt_q;
  logic              inflight_q;
  logic              busy_q;
  logic              accept;
  logic              pop;
  logic              issue;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [2:0]        occ;

  assign accept = (state_q == IDLE) && start;
  assign pop    = M_AXIS_tvalid && M_AXIS_tready;

  // occupancy counts the word still in the RAM pipe
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight_q};
  assign issue = (state_q == STREAM)
              && (rd_ptr_q < {1'b0, n_q})
              && (occ < (3'd2 + {2'b00, pop}))
              && !(fifo_full && !pop);

  assign mem_en   = issue;
  assign mem_addr = issue ? rd_ptr_q[ADDR_W-1:0] : '0;

  assign M_AXIS_tvalid = !fifo_empty;
  assign M_AXIS_tlast  = M_AXIS_tvalid
                      && (beat_cnt_q == n_q - ADDR_W'(1));
  assign busy = busy_q;

  ntru_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight_q),
    .pop    (pop),
    .din    (mem_rdata),
    .dout   (M_AXIS_tdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (poly_n == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        if (pop && M_AXIS_tlast) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      n_q        <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (accept) begin
        n_q        <= poly_n;
        rd_ptr_q   <= '0;
        beat_cnt_q <= '0;
        busy_q     <= 1'b1;
      end else begin
        if (issue) rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        if (pop)   beat_cnt_q <= beat_cnt_q + ADDR_W'(1);
        if (state_q == FINISH) busy_q <= 1'b0;
      end
    end
  end

`ifdef NTRU_STREAM_CYCLECOUNT_EN
  logic [31:0] cc_q;

  always_ff @(posedge clk) begin
    if (!resetn)                     cc_q <= '0;
    else if (accept)                 cc_q <= '0;
    else if (busy_q && (cc_q != '1)) cc_q <= cc_q + 32'd1;
  end

  assign cycle_count = cc_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_ntru_axis_poly_streamer.sv
// Bench for ntru_axis_poly_streamer: vector table plus scoreboard
// of expected beats checked on every stream handshake.
module tb_ntru_axis_poly_streamer;

  localparam int DW = 32;
  localparam int AW = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int n;
    int pat;
    int fv;
    int lb;
    int dk;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] poly_n;
  logic          busy;
  logic          done;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] M_AXIS_tdata;
  logic          M_AXIS_tvalid;
  logic          M_AXIS_tready;
  logic          M_AXIS_tlast;
  logic [31:0]   cycle_count;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  beat_t         sb[$];
  int            total = 0;
  int            bad = 0;
  int            done_cnt = 0;
  logic          stall_q = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;

  always #5 clk = ~clk;

  ntru_axis_poly_streamer dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .poly_n        (poly_n),
    .busy          (busy),
    .done          (done),
    .mem_en        (mem_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .cycle_count   (cycle_count)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      if (mem_en) mem_rdata <= ram[mem_addr];
    end
  end

  // scoreboard consumer and stall-stability monitor
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (stall_q && M_AXIS_tvalid) begin
        chk("stall_tdata", M_AXIS_tdata, hold_d);
        chk("stall_tlast", M_AXIS_tlast, hold_l);
      end
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got tdata %0d expected no beat",
                   M_AXIS_tdata);
        end else begin
          e = sb.pop_front();
          chk("tdata", M_AXIS_tdata, e.data);
          chk("tlast", M_AXIS_tlast, e.last);
        end
      end
      stall_q = M_AXIS_tvalid && !M_AXIS_tready;
      hold_d  = M_AXIS_tdata;
      hold_l  = M_AXIS_tlast;
      if (done) done_cnt++;
    end
  end

  // called just after a posedge; returns just after a posedge
  task automatic run_packet(input int n, input int pat, input int inj,
                            input int rst_at, output int fv, output int lb,
                            output int dk, output int beats, output int bc,
                            output logic [31:0] cc);
    beat_t e;
    bit injected;
    injected = 0;
    fv = -1; lb = -1; dk = -1; beats = 0; bc = 0;
    start  = 1'b1;
    poly_n = AW'(n);
    for (int i = 0; i < n; i++) begin
      e.data = DW'(i);
      e.last = (i == n - 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4000; k++) begin
      M_AXIS_tready = (pat == 0) ? 1'b1 : ((k % 4) >= 2);
      if (inj >= 0 && !injected && beats >= inj) begin
        start    = 1'b1;
        injected = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) bc++;
      if (M_AXIS_tvalid && fv < 0) fv = k;
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        beats++;
        lb = k;
      end
      if (done) begin
        dk = k;
        break;
      end
      if (rst_at >= 0 && beats == rst_at) begin
        @(posedge clk); #1;
        M_AXIS_tready = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        sb.delete();
        break;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
    cc = cycle_count;
  endtask

  task automatic chk_cc(input logic [31:0] cc, input int exp);
`ifdef NTRU_STREAM_CYCLECOUNT_EN
    chk("cycle_count", cc, exp);
`else
    if (exp >= 0) chk("cycle_count", cc, 0);
`endif
  endtask

  initial begin
    vec_t        vecs[5];
    int          fv, lb, dk, beats, bc, d0, cnt;
    logic [31:0] cc;

    vecs[0] = '{821, 0, 3, 823, 824};
    vecs[1] = '{821, 1, 3, -1, -1};
    vecs[2] = '{1, 0, 3, 3, 4};
    vecs[3] = '{0, 0, -1, -1, 1};
    vecs[4] = '{7, 1, 3, -1, -1};

    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    resetn = 1'b0;
    start = 1'b0;
    poly_n = '0;
    M_AXIS_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0_busy", busy, 0);
    chk("rst0_done", done, 0);
    chk("rst0_mem_en", mem_en, 0);
    chk("rst0_mem_addr", mem_addr, 0);
    chk("rst0_tvalid", M_AXIS_tvalid, 0);
    chk("rst0_tlast", M_AXIS_tlast, 0);
    chk("rst0_tdata", M_AXIS_tdata, 0);
    chk("rst0_cycle_count", cycle_count, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      run_packet(vecs[v].n, vecs[v].pat, -1, -1, fv, lb, dk, beats, bc, cc);
      chk($sformatf("v%0d_first_valid", v), fv, vecs[v].fv);
      if (vecs[v].lb >= 0) chk($sformatf("v%0d_last_beat", v), lb, vecs[v].lb);
      if (vecs[v].dk >= 0) chk($sformatf("v%0d_done_cyc", v), dk, vecs[v].dk);
      chk($sformatf("v%0d_done_gap", v), dk, (vecs[v].n == 0) ? 1 : lb + 1);
      chk($sformatf("v%0d_beats", v), beats, vecs[v].n);
      chk($sformatf("v%0d_busy_cycles", v), bc, dk);
      chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
      chk_cc(cc, dk);
    end

    // start pulsed while busy must be dropped
    d0 = done_cnt;
    run_packet(821, 0, 100, -1, fv, lb, dk, beats, bc, cc);
    chk("inj_last_beat", lb, 823);
    chk("inj_done_cyc", dk, 824);
    chk("inj_beats", beats, 821);
    chk_cc(cc, 824);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (M_AXIS_tvalid) cnt++;
    end
    chk("inj_idle_tvalid", cnt, 0);
    chk("inj_done_pulses", done_cnt - d0, 1);
    @(posedge clk); #1;

    // reset mid-stream with the sink stalled
    d0 = done_cnt;
    run_packet(821, 0, -1, 400, fv, lb, dk, beats, bc, cc);
    chk("rst_beats", beats, 400);
    chk("rst_no_done", done_cnt - d0, 0);
    chk_cc(cc, 0);
    run_packet(16, 0, -1, -1, fv, lb, dk, beats, bc, cc);
    chk("fresh_first_valid", fv, 3);
    chk("fresh_done_cyc", dk, 19);
    chk("fresh_beats", beats, 16);

    // back-to-back packets; second start lands the cycle after done
    d0 = done_cnt;
    run_packet(443, 0, -1, -1, fv, lb, dk, beats, bc, cc);
    chk("b2b1_last_beat", lb, 445);
    chk("b2b1_done_cyc", dk, 446);
    chk("b2b1_beats", beats, 443);
    run_packet(701, 0, -1, -1, fv, lb, dk, beats, bc, cc);
    chk("b2b2_first_valid", fv, 3);
    chk("b2b2_last_beat", lb, 703);
    chk("b2b2_done_cyc", dk, 704);
    chk("b2b2_beats", beats, 701);
    chk_cc(cc, 704);
    chk("b2b_done_pulses", done_cnt - d0, 2);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
